// File: rtl/pll_mdrp_pkg.sv
// Shared widths, MDRP opcodes, controller states and the captured host request.
package pll_mdrp_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned OPC_W  = 2;

  typedef enum logic [OPC_W-1:0] {
    OPC_NOP = 2'b00,
    OPC_WR  = 2'b01,
    OPC_RD  = 2'b10
  } mdopc_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEEK,
    ST_OP,
    ST_RDWAIT,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mdrp_req_t;

  // Opcode presented on the pins once the PLL address matches the target.
  function automatic mdopc_e op_for(input logic we);
    return we ? OPC_WR : OPC_RD;
  endfunction

endpackage

// File: rtl/mdrp_clkgen.sv
// Free-running MDCLK divider; ftick/rtick flag the clk cycle before a falling/rising mdclk edge.
module mdrp_clkgen #(
  parameter int unsigned MDCLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  output logic mdclk,
  output logic ftick,
  output logic rtick
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MDCLK_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_d;
  logic             mdclk_d;
  logic             wrap;

  always_comb begin
    wrap    = (cnt == LAST);
    cnt_d   = wrap ? '0 : cnt + 1'b1;
    mdclk_d = wrap ? ~mdclk : mdclk;
  end

  // Ticks are decoded from the next counter state so they line up with cnt==LAST.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      mdclk <= 1'b0;
      ftick <= 1'b0;
      rtick <= (MDCLK_DIV == 1);
    end else begin
      cnt   <= cnt_d;
      mdclk <= mdclk_d;
      ftick <= (cnt_d == LAST) && mdclk_d;
      rtick <= (cnt_d == LAST) && !mdclk_d;
    end
  end

endmodule

// File: rtl/pll_mdrp_ctrl.sv
// Host-to-PLL MDRP bridge: walks the PLL address pointer with MDAINC, then issues one WR/RD.
module pll_mdrp_ctrl
  import pll_mdrp_pkg::*;
#(
  parameter int unsigned MDCLK_DIV = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              ack,
  output logic [DATA_W-1:0] rdata,
  output logic              mdclk,
  output logic [OPC_W-1:0]  mdopc,
  output logic              mdainc,
  output logic [DATA_W-1:0] mdwdi,
  input  logic [DATA_W-1:0] mdrdo
);

  logic ftick;
  logic rtick;

  state_e            state, state_d;
  mdrp_req_t         cur, cur_d;
  logic [ADDR_W-1:0] ptr, ptr_d;
  mdopc_e            opc_q, opc_d;
  logic              busy_d;
  logic              ack_d;
  logic [DATA_W-1:0] rdata_d;
  logic              mdainc_d;
  logic [DATA_W-1:0] mdwdi_d;

  mdrp_clkgen #(.MDCLK_DIV(MDCLK_DIV)) u_clkgen (
    .clk   (clk),
    .reset (reset),
    .mdclk (mdclk),
    .ftick (ftick),
    .rtick (rtick)
  );

  assign mdopc = opc_q;

  // Next-state and next-output logic; pin values only move on ftick.
  always_comb begin
    state_d  = state;
    cur_d    = cur;
    ptr_d    = ptr;
    opc_d    = opc_q;
    busy_d   = busy;
    ack_d    = 1'b0;
    rdata_d  = rdata;
    mdainc_d = mdainc;
    mdwdi_d  = mdwdi;

    unique case (state)
      ST_IDLE: begin
        if (req) begin
          cur_d   = '{we: we, addr: addr, wdata: wdata};
          busy_d  = 1'b1;
          state_d = ST_SEEK;
        end
      end
      ST_SEEK: begin
        if (ftick) begin
          if (ptr != cur.addr) begin
            mdainc_d = 1'b1;
            ptr_d    = ptr + 1'b1;
          end else begin
            mdainc_d = 1'b0;
            opc_d    = op_for(cur.we);
            mdwdi_d  = cur.we ? cur.wdata : '0;
            state_d  = ST_OP;
          end
        end
      end
      ST_OP: begin
        if (ftick) begin
          opc_d   = OPC_NOP;
          mdwdi_d = '0;
          if (cur.we) begin
            ack_d   = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_DONE;
          end else begin
            state_d = ST_RDWAIT;
          end
        end
      end
      ST_RDWAIT: begin
        // PLL presented read data at the rising edge inside the RD period.
        if (rtick) begin
          rdata_d = mdrdo;
          ack_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      cur    <= '0;
      ptr    <= '0;
      opc_q  <= OPC_NOP;
      busy   <= 1'b0;
      ack    <= 1'b0;
      rdata  <= '0;
      mdainc <= 1'b0;
      mdwdi  <= '0;
    end else begin
      state  <= state_d;
      cur    <= cur_d;
      ptr    <= ptr_d;
      opc_q  <= opc_d;
      busy   <= busy_d;
      ack    <= ack_d;
      rdata  <= rdata_d;
      mdainc <= mdainc_d;
      mdwdi  <= mdwdi_d;
    end
  end

endmodule

// File: doc/pll_mdrp_ctrl.md
PLL_MDRP_CTRL -- requirements
Module: pll_mdrp_ctrl

Interface
REQ-001 SHALL have parameter MDCLK_DIV, default 2, meaning the MDCLK half-period in clk cycles (legal 1..255).
REQ-002 SHALL have port clk, input, 1 bit: the single system clock.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port req, input, 1 bit: host access request.
REQ-005 SHALL have port we, input, 1 bit: 1 selects write, 0 selects read.
REQ-006 SHALL have port addr, input, 8 bits: PLL MDRP register address.
REQ-007 SHALL have port wdata, input, 8 bits: write data.
REQ-008 SHALL have port busy, output, 1 bit: access in progress.
REQ-009 SHALL have port ack, output, 1 bit: one-clk pulse marking access complete.
REQ-010 SHALL have port rdata, output, 8 bits: read result, valid while ack=1.
REQ-011 SHALL have ports mdclk (output, 1), mdopc (output, 2), mdainc (output, 1), mdwdi (output, 8) and mdrdo (input, 8), driving and reading the PLL MDCLK, MDOPC, MDAINC, MDWDI and MDRDO pins.

Function
REQ-012 SHALL generate mdclk from clk: it toggles every MDCLK_DIV clk cycles, giving a period of 2*MDCLK_DIV clk cycles, and is free-running from reset.
REQ-013 SHALL define ftick as the clk cycle before mdclk falls, and rtick as the clk cycle before mdclk rises.
REQ-014 SHALL change mdopc, mdainc and mdwdi only on ftick, so each value is held for exactly one MDCLK period.
REQ-015 SHALL encode mdopc as NOP=2'b00, WR=2'b01, RD=2'b10; 2'b11 SHALL never be driven.
REQ-016 SHALL keep an 8-bit shadow pointer ptr that mirrors the PLL internal address; ptr resets to 0.
REQ-017 SHALL accept a request when req=1 and busy=0 in IDLE: capture we/addr/wdata, and set busy=1 on the next cycle.
REQ-018 SHALL ignore req while busy=1; captured values SHALL NOT change mid-access.
REQ-019 SHALL implement state machine IDLE -> SEEK -> OP -> (RDWAIT if read) -> DONE -> IDLE.
REQ-020 SEEK: at each ftick with ptr!=addr, SHALL assert mdainc=1 for one MDCLK period and set ptr=ptr+1 mod 256.
REQ-021 SEEK: at the first ftick with ptr==addr, SHALL drive mdopc=WR (with mdwdi=wdata) or mdopc=RD for one MDCLK period (state OP), and mdainc=0.
REQ-022 Wrap-around: when addr<ptr, SHALL issue 256-ptr+addr increments; when addr==ptr, zero increments.
REQ-023 OP: at the next ftick SHALL return mdopc to NOP and mdwdi to 0x00; a write goes to DONE, a read goes to RDWAIT.
REQ-024 RDWAIT: SHALL sample mdrdo into rdata on the first rtick after entering, then go to DONE.
REQ-025 DONE: SHALL pulse ack=1 for one clk cycle, drop busy in that same cycle, and return to IDLE; a new req is accepted no earlier than the cycle after ack.
REQ-026 SHALL hold rdata stable until the next read completes; writes SHALL NOT alter rdata.
REQ-027 SHALL NOT issue mdainc and a non-NOP mdopc in the same MDCLK period.

Reset
REQ-028 On reset SHALL immediately force state=IDLE, busy=0, ack=0, rdata=0x00, mdclk=0, mdopc=NOP, mdainc=0, mdwdi=0x00, ptr=0, and clear the divider counter.
REQ-029 Reset asserted mid-access SHALL abort it with no ack; the PLL SHALL be reset by the same reset so that its address matches ptr=0.

Structure
REQ-030 SHALL place the opcode constants, state enum, ADDR_W=8 and DATA_W=8 in package pll_mdrp_pkg.
REQ-031 SHALL implement the divider as sub-module mdrp_clkgen, producing mdclk, ftick and rtick.

Verification
REQ-032 Bench SHALL check: reset release, MDCLK_DIV=2 -> mdclk period 4 clks, all outputs at reset values, busy=0.
REQ-033 Bench SHALL check: write 0x5A to addr 0x03 from ptr=0 -> exactly 3 mdainc periods, then one WR period with mdwdi=0x5A, one ack, ptr=3.
REQ-034 Bench SHALL check: read addr 0x01 from ptr=3 with the PLL model holding 0xC3 -> 254 mdainc periods (wrap), RD period, rdata=0xC3 at ack.
REQ-035 Bench SHALL check: read addr equal to ptr -> zero mdainc pulses, ack within 3 MDCLK periods of acceptance.
REQ-036 Bench SHALL check: req held high during a busy access -> ignored, with exactly one ack per accepted request.
REQ-037 Bench SHALL check: reset asserted during SEEK -> immediate reset values and no ack; a following access to 0x02 issues exactly 2 increments.
